// File: rtl/sdram_arbit.sv
// sdram_arbit: owns the SDRAM command bus. Grants it to the init, write or
// read engine, or to its own auto-refresh sequencer. Registers the selected
// command, address, bank and write data onto the SDRAM pins.
module sdram_arbit #(
    parameter int REF_PERIOD = 780,  // sclk cycles between refresh requests
    parameter int TRC_CYC    = 7     // cycles spent in S_AREF, AREF cycle included
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        wr_req,
    input  logic        flag_wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic [15:0] wr_data,
    input  logic        rd_req,
    input  logic        flag_rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    input  logic [1:0]  rd_bank,
    output logic        wr_en,
    output logic        rd_en,
    output logic        ref_req,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_bank,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam int REF_W = $clog2(REF_PERIOD);
    localparam int TRC_W = $clog2(TRC_CYC + 1);

    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REF_PERIOD - 1);
    localparam logic [TRC_W-1:0] AREF_LAST = TRC_W'(TRC_CYC - 1);

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_t;

    state_t             state_q, state_d;
    logic [TRC_W-1:0]   aref_cnt_q, aref_cnt_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic               ref_req_q, ref_req_d;
    logic               ref_wrap;
    logic [3:0]         cmd_q, cmd_d;
    logic [12:0]        addr_q, addr_d;
    logic [1:0]         bank_q, bank_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;

    // Next state: fixed priority refresh > write > read out of S_ARBIT.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the block infers a latch.
        state_d = state_q;
        case (state_q)
            S_INIT:  if (init_end)                state_d = S_ARBIT;
            S_ARBIT: begin
                if (ref_req_q)                    state_d = S_AREF;
                else if (wr_req)                  state_d = S_WRITE;
                else if (rd_req)                  state_d = S_READ;
            end
            S_AREF:  if (aref_cnt_q == AREF_LAST) state_d = S_ARBIT;
            S_WRITE: if (flag_wr_end)             state_d = S_ARBIT;
            S_READ:  if (flag_rd_end)             state_d = S_ARBIT;
            default:                              state_d = S_INIT;
        endcase
    end

    // Cycle counter inside S_AREF; returns to 0 on the exit cycle so it reads 0 elsewhere.
    always_comb begin
        aref_cnt_d = '0;
        if (state_q == S_AREF && aref_cnt_q != AREF_LAST) begin
            aref_cnt_d = aref_cnt_q + TRC_W'(1);
        end
    end

    // Free-running refresh timer, held at 0 until init completes; a wrap beats the clear on S_AREF entry.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        ref_wrap  = 1'b0;
        if (!init_end) begin
            ref_cnt_d = '0;
        end else if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            ref_wrap  = 1'b1;
        end else begin
            ref_cnt_d = ref_cnt_q + REF_W'(1);
        end

        ref_req_d = ref_req_q;
        if (ref_wrap) begin
            ref_req_d = 1'b1;
        end else if (state_q != S_AREF && state_d == S_AREF) begin
            ref_req_d = 1'b0;
        end
    end

    // Command mux selected by the current state; the pins get it one cycle later.
    always_comb begin
        cmd_d    = CMD_NOP;
        addr_d   = '0;
        bank_d   = '0;
        dq_out_d = wr_data;
        dq_oe_d  = (state_q == S_WRITE);
        case (state_q)
            S_INIT: begin
                cmd_d  = init_cmd;
                addr_d = init_addr;
            end
            S_WRITE: begin
                cmd_d  = wr_cmd;
                addr_d = wr_addr;
                bank_d = wr_bank;
            end
            S_READ: begin
                cmd_d  = rd_cmd;
                addr_d = rd_addr;
                bank_d = rd_bank;
            end
            S_AREF: begin
                cmd_d = (aref_cnt_q == '0) ? CMD_AREF : CMD_NOP;
            end
            default: ;
        endcase
    end

    // All state and pin registers; reset puts NOP on the bus and drops every grant.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q    <= S_INIT;
            aref_cnt_q <= '0;
            ref_cnt_q  <= '0;
            ref_req_q  <= 1'b0;
            cmd_q      <= CMD_NOP;
            addr_q     <= '0;
            bank_q     <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
            state_q    <= state_d;
            aref_cnt_q <= aref_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_req_q  <= ref_req_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
    assign sdram_addr   = addr_q;
    assign sdram_bank   = bank_q;
    assign sdram_dq_out = dq_out_q;
    assign sdram_dq_oe  = dq_oe_q;
    assign sdram_cke    = 1'b1;
    assign wr_en        = (state_q == S_WRITE);
    assign rd_en        = (state_q == S_READ);
    assign ref_req      = ref_req_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: scenario tasks drive the engines; expected pin values
// are queued when the engine outputs are driven and compared one edge later.
module tb_sdram_arbit;

    localparam int REF_PERIOD = 780;
    localparam int TRC_CYC    = 7;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] WR   = 4'b0100;
    localparam logic [3:0] RD   = 4'b0101;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        init_end = 1'b0;
    logic [3:0]  init_cmd = 4'b0111;
    logic [12:0] init_addr = 13'h0;
    logic        wr_req = 1'b0;
    logic        flag_wr_end = 1'b0;
    logic [3:0]  wr_cmd = 4'b0111;
    logic [12:0] wr_addr = 13'h0;
    logic [1:0]  wr_bank = 2'd0;
    logic [15:0] wr_data = 16'h0;
    logic        rd_req = 1'b0;
    logic        flag_rd_end = 1'b0;
    logic [3:0]  rd_cmd = 4'b0111;
    logic [12:0] rd_addr = 13'h0;
    logic [1:0]  rd_bank = 2'd0;
    logic        wr_en, rd_en, ref_req, sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_bank;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  bank;
        logic [15:0] dq;
        logic        oe;
    } pins_t;

    pins_t act_pins;
    pins_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    n = 0;    // rising edges seen
    int    e0 = 0;   // edge at which init_end was first sampled high

    sdram_arbit #(.REF_PERIOD(REF_PERIOD), .TRC_CYC(TRC_CYC)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd),
        .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
        .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd),
        .rd_addr(rd_addr), .rd_bank(rd_bank),
        .wr_en(wr_en), .rd_en(rd_en), .ref_req(ref_req), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 sclk = ~sclk;

    assign act_pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                       sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe};

    // Queue the pin image expected after the next edge, from the engine values now driven.
    task automatic expect_pins(input logic [3:0] c, input logic [12:0] a,
                               input logic [1:0] b, input logic oe);
        exp_q.push_back({c, a, b, wr_data, oe});
    endtask

    // Advance one edge, sample 1 time unit later, and retire one scoreboard entry if queued.
    task automatic tick();
        pins_t e;
        @(posedge sclk);
        #1;
        n++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_pins !== e) begin
                failures++;
                $display("FAIL pins edge=%0d: got %h expected %h (cmd,addr,bank,dq,oe)", n, act_pins, e);
            end
        end
    endtask

    function automatic int phase();
        return (n - e0) % REF_PERIOD;
    endfunction

    task automatic wait_phase(input int p);
        for (int i = 0; i < 2 * REF_PERIOD && phase() != p; i++) tick();
    endtask

    // Called right after the edge that entered S_AREF: one AREF, then NOPs, no grants.
    task automatic aref_window();
        for (int k = 1; k <= TRC_CYC; k++) begin
            expect_pins((k == 1) ? AREF : NOP, 13'h0, 2'd0, 1'b0);
            tick();
            checks++;
            if ({wr_en, rd_en} !== 2'b00) begin
                failures++;
                $display("FAIL aref_no_grant k=%0d: wr_en,rd_en=%b expected 00", k, {wr_en, rd_en});
            end
        end
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if (act_pins !== {NOP, 13'h0, 2'd0, 16'h0, 1'b0}) begin
            failures++; $display("FAIL reset_pins: got %h expected %h", act_pins, {NOP, 13'h0, 2'd0, 16'h0, 1'b0});
        end
        checks++;
        if ({sdram_cke, wr_en, rd_en, ref_req} !== 4'b1000) begin
            failures++; $display("FAIL reset_ctrl: cke,wr_en,rd_en,ref_req=%b expected 1000", {sdram_cke, wr_en, rd_en, ref_req});
        end
        @(negedge sclk);
        s_rst_n = 1'b1;
        init_cmd = PRE; init_addr = 13'h0400; wr_data = 16'hA5A5; wr_req = 1'b1; rd_req = 1'b1;
        expect_pins(PRE, 13'h0400, 2'd0, 1'b0);
        tick();
        checks++;
        if ({wr_en, rd_en} !== 2'b00) begin
            failures++; $display("FAIL init_no_grant: wr_en,rd_en=%b expected 00", {wr_en, rd_en});
        end
        init_cmd = NOP; init_addr = 13'h0; wr_req = 1'b0; rd_req = 1'b0; wr_data = 16'h0;
        repeat (8) begin
            expect_pins(NOP, 13'h0, 2'd0, 1'b0);
            tick();
        end
        checks++;
        if (ref_req !== 1'b0) begin
            failures++; $display("FAIL init_no_ref: ref_req=%b expected 0", ref_req);
        end
    endtask

    task automatic test_refresh();
        init_end = 1'b1;
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        e0 = n;
        for (int i = 0; i < REF_PERIOD - 2; i++) tick();
        checks++;
        if (ref_req !== 1'b0) begin
            failures++; $display("FAIL ref_early: ref_req=%b expected 0 at phase %0d", ref_req, phase());
        end
        tick();
        checks++;
        if (ref_req !== 1'b1) begin
            failures++; $display("FAIL ref_rise: ref_req=%b expected 1 at phase %0d", ref_req, phase());
        end
        // Write engine asks for the bus with junk outputs that must not reach the pins.
        wr_req = 1'b1; wr_cmd = ACT; wr_addr = 13'h1FFF; wr_bank = 2'd3;
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        checks++;
        if ({ref_req, wr_en} !== 2'b00) begin
            failures++; $display("FAIL ref_clear_entry: ref_req,wr_en=%b expected 00", {ref_req, wr_en});
        end
        aref_window();
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        checks++;
        if (wr_en !== 1'b1) begin
            failures++; $display("FAIL aref_exit_grant: wr_en=%b expected 1", wr_en);
        end
        wr_req = 1'b0; wr_cmd = NOP; wr_addr = 13'h0; wr_bank = 2'd0; flag_wr_end = 1'b1;
        expect_pins(NOP, 13'h0, 2'd0, 1'b1);
        tick();
        flag_wr_end = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            failures++; $display("FAIL refresh_wr_release: wr_en=%b expected 0", wr_en);
        end
    endtask

    task automatic test_write();
        wr_req = 1'b1; wr_cmd = ACT; wr_addr = 13'h1FFF; wr_bank = 2'd3; wr_data = 16'h1234;
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        checks++;
        if (wr_en !== 1'b1) begin
            failures++; $display("FAIL wr_grant: wr_en=%b expected 1", wr_en);
        end
        wr_addr = 13'h005; wr_bank = 2'd1; flag_rd_end = 1'b1;
        expect_pins(ACT, 13'h005, 2'd1, 1'b1);
        tick();
        flag_rd_end = 1'b0;
        checks++;
        if (wr_en !== 1'b1) begin
            failures++; $display("FAIL wr_ignores_rd_end: wr_en=%b expected 1", wr_en);
        end
        wr_cmd = WR; wr_addr = 13'h010; wr_data = 16'hBEEF;
        expect_pins(WR, 13'h010, 2'd1, 1'b1);
        tick();
        wr_cmd = PRE; wr_addr = 13'h0400;
        expect_pins(PRE, 13'h0400, 2'd1, 1'b1);
        tick();
        wr_cmd = NOP; wr_addr = 13'h0; wr_bank = 2'd0; wr_req = 1'b0; flag_wr_end = 1'b1;
        expect_pins(NOP, 13'h0, 2'd0, 1'b1);
        tick();
        flag_wr_end = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            failures++; $display("FAIL wr_release: wr_en=%b expected 0", wr_en);
        end
        wr_addr = 13'h0ABC;
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        wr_addr = 13'h0;
    endtask

    task automatic test_both();
        wr_req = 1'b1; rd_req = 1'b1; wr_cmd = NOP; wr_data = 16'h5A5A;
        rd_cmd = RD; rd_addr = 13'h0123; rd_bank = 2'd2;
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        checks++;
        if ({wr_en, rd_en} !== 2'b10) begin
            failures++; $display("FAIL both_write_first: wr_en,rd_en=%b expected 10", {wr_en, rd_en});
        end
        wr_cmd = WR; wr_addr = 13'h020; wr_bank = 2'd2;
        expect_pins(WR, 13'h020, 2'd2, 1'b1);
        tick();
        wr_cmd = NOP; wr_addr = 13'h0; wr_bank = 2'd0; wr_req = 1'b0; flag_wr_end = 1'b1;
        expect_pins(NOP, 13'h0, 2'd0, 1'b1);
        tick();
        flag_wr_end = 1'b0;
        checks++;
        if ({wr_en, rd_en} !== 2'b00) begin
            failures++; $display("FAIL both_back_to_arbit: wr_en,rd_en=%b expected 00", {wr_en, rd_en});
        end
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        checks++;
        if ({wr_en, rd_en} !== 2'b01) begin
            failures++; $display("FAIL both_read_next: wr_en,rd_en=%b expected 01", {wr_en, rd_en});
        end
        flag_wr_end = 1'b1;
        expect_pins(RD, 13'h0123, 2'd2, 1'b0);
        tick();
        flag_wr_end = 1'b0;
        checks++;
        if (rd_en !== 1'b1) begin
            failures++; $display("FAIL rd_ignores_wr_end: rd_en=%b expected 1", rd_en);
        end
        rd_cmd = NOP; rd_addr = 13'h0; rd_bank = 2'd0; rd_req = 1'b0; flag_rd_end = 1'b1;
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        flag_rd_end = 1'b0;
        checks++;
        if (rd_en !== 1'b0) begin
            failures++; $display("FAIL rd_release: rd_en=%b expected 0", rd_en);
        end
    endtask

    task automatic test_ref_in_write();
        wr_req = 1'b1; wr_cmd = NOP; wr_data = 16'hC3C3;
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        wait_phase(REF_PERIOD - 1);
        repeat (3) tick();
        checks++;
        if ({ref_req, wr_en} !== 2'b11) begin
            failures++; $display("FAIL ref_waits_for_write: ref_req,wr_en=%b expected 11", {ref_req, wr_en});
        end
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        checks++;
        if ({ref_req, wr_en} !== 2'b10) begin
            failures++; $display("FAIL ref_write_end: ref_req,wr_en=%b expected 10", {ref_req, wr_en});
        end
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        checks++;
        if ({ref_req, wr_en} !== 2'b00) begin
            failures++; $display("FAIL ref_beats_wr_req: ref_req,wr_en=%b expected 00", {ref_req, wr_en});
        end
        aref_window();
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        checks++;
        if (wr_en !== 1'b1) begin
            failures++; $display("FAIL ref_then_write: wr_en=%b expected 1", wr_en);
        end
        wr_req = 1'b0; flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
    endtask

    task automatic test_wrap_on_entry();
        wr_req = 1'b1; wr_cmd = NOP; wr_data = 16'h0;
        tick();
        wait_phase(REF_PERIOD - 1);
        wait_phase(REF_PERIOD - 3);
        checks++;
        if ({ref_req, wr_en} !== 2'b11) begin
            failures++; $display("FAIL wrap_pending: ref_req,wr_en=%b expected 11", {ref_req, wr_en});
        end
        wr_req = 1'b0; flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        checks++;
        if (ref_req !== 1'b1) begin
            failures++; $display("FAIL wrap_on_entry: ref_req=%b expected 1 at phase %0d", ref_req, phase());
        end
        aref_window();
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        checks++;
        if (ref_req !== 1'b0) begin
            failures++; $display("FAIL second_aref_entry: ref_req=%b expected 0", ref_req);
        end
        aref_window();
        expect_pins(NOP, 13'h0, 2'd0, 1'b0);
        tick();
        checks++;
        if ({ref_req, wr_en, rd_en} !== 3'b000) begin
            failures++; $display("FAIL after_second_aref: ref_req,wr_en,rd_en=%b expected 000", {ref_req, wr_en, rd_en});
        end
    endtask

    task automatic test_reset_mid();
        wr_req = 1'b1; wr_cmd = NOP;
        tick();
        wr_cmd = WR; wr_addr = 13'h044; wr_bank = 2'd1; wr_data = 16'h0F0F;
        expect_pins(WR, 13'h044, 2'd1, 1'b1);
        tick();
        #3;
        s_rst_n = 1'b0;
        init_end = 1'b0;
        #1;
        checks++;
        if (act_pins !== {NOP, 13'h0, 2'd0, 16'h0, 1'b0}) begin
            failures++; $display("FAIL rst_async_pins: got %h expected %h", act_pins, {NOP, 13'h0, 2'd0, 16'h0, 1'b0});
        end
        checks++;
        if ({wr_en, rd_en, ref_req} !== 3'b000) begin
            failures++; $display("FAIL rst_async_ctrl: wr_en,rd_en,ref_req=%b expected 000", {wr_en, rd_en, ref_req});
        end
        repeat (2) tick();
        @(negedge sclk);
        s_rst_n = 1'b1;
        init_cmd = PRE; init_addr = 13'h0400;
        expect_pins(PRE, 13'h0400, 2'd0, 1'b0);
        tick();
        init_cmd = NOP; init_addr = 13'h0;
        repeat (4) tick();
        checks++;
        if ({wr_en, ref_req} !== 2'b00) begin
            failures++; $display("FAIL rst_hold_init: wr_en,ref_req=%b expected 00", {wr_en, ref_req});
        end
        init_end = 1'b1;
        tick();
        tick();
        checks++;
        if (wr_en !== 1'b1) begin
            failures++; $display("FAIL rst_resume: wr_en=%b expected 1", wr_en);
        end
        wr_req = 1'b0; wr_cmd = NOP; flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_write();
        test_both();
        test_ref_in_write();
        test_wrap_on_entry();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, edges=%0d", n);
        $fatal(1, "watchdog expired");
    end

endmodule
